// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: serial FSM state encodings and the
// saturation limit helper used when a result must clamp on signed overflow.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns -2^(width-1) when neg is set, else 2^(width-1)-1; caller truncates to width.
    function automatic logic [63:0] sat_limit(input int width, input logic neg);
        logic [63:0] msb_only;
        msb_only = 64'd1 << (width - 1);
        return neg ? msb_only : (msb_only - 64'd1);
    endfunction

endpackage

// File: rtl/sub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial signed subtractor, diff = a - b, LSB first over Width cycles.
// Define SUB_SERIAL_SAT_EN to saturate diff_o on signed overflow instead of wrapping.
module sub_serial #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] diff_o,
    output logic             ovf_o
);
    import arith_pkg::*;

    localparam int CW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(Width - 1);

    state_t           state_q, state_d;
    logic [Width-1:0] a_sh_q, a_sh_d;
    logic [Width-1:0] b_sh_q, b_sh_d;
    // Holds the bits already produced; the bit being computed is prepended on the fly.
    logic [Width-2:0] res_sh_q, res_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [Width-1:0] diff_q, diff_d;

    logic             cell_d;
    logic             cell_bout;
    logic [Width-1:0] res_next;
    logic             ovf_now;
`ifdef SUB_SERIAL_SAT_EN
    logic [Width-1:0] sat_val;
`endif

    sub_cell u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (borrow_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        diff_d   = diff_q;

        res_next = {cell_d, res_sh_q};
        // On the last bit the shifted-down operands expose their original MSBs.
        ovf_now  = (a_sh_q[0] != b_sh_q[0]) && (cell_d != a_sh_q[0]);
`ifdef SUB_SERIAL_SAT_EN
        sat_val  = Width'(sat_limit(Width, a_sh_q[0]));
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_sh_d   = a_i;
                    b_sh_d   = b_i;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[Width-1:1]};
                b_sh_d   = {1'b0, b_sh_q[Width-1:1]};
                res_sh_d = res_next[Width-1:1];
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_now;
`ifdef SUB_SERIAL_SAT_EN
                    diff_d  = ovf_now ? sat_val : res_next;
`else
                    diff_d  = res_next;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            diff_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            diff_q   <= diff_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial at Width=8 and Width=32; expected values follow
// SUB_SERIAL_SAT_EN when the bench is built with that macro.
module tb_sub_serial;

`ifdef SUB_SERIAL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, diff8;
    logic        busy8, done8, ovf8;
    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, diff32;
    logic        busy32, done32, ovf32;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [8:0]  q8[$];
    logic [32:0] q32[$];
    int          done_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sub_serial #(.Width(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .diff_o(diff8), .ovf_o(ovf8)
    );

    sub_serial #(.Width(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start32), .a_i(a32), .b_i(b32),
        .busy_o(busy32), .done_o(done32), .diff_o(diff32), .ovf_o(ovf32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitors: pop one expected response per done pulse.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done8: got done with diff %0h, expected no done", diff8);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                $display("op8  diff=%h ovf=%b (exp %h/%b) cyc=%0d", diff8, ovf8, e[7:0], e[8], cyc);
                check("diff8", 64'(diff8), 64'(e[7:0]));
                check("ovf8", 64'(ovf8), 64'(e[8]));
                done_cyc.push_back(cyc);
            end
        end
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done32: got done with diff %0h, expected no done", diff32);
            end else begin
                logic [32:0] e;
                e = q32.pop_front();
                $display("op32 diff=%h ovf=%b (exp %h/%b)", diff32, ovf32, e[31:0], e[32]);
                check("diff32", 64'(diff32), 64'(e[31:0]));
                check("ovf32", 64'(ovf32), 64'(e[32]));
            end
        end
    end

    task automatic wait_idle8();
        int g = 0;
        @(negedge clk);
        while (busy8 && g < 50) begin @(negedge clk); g++; end
        if (busy8) check("idle8_timeout", 64'(busy8), 64'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed_wrap, input logic [7:0] ed_sat, input logic eo);
        int cycles;
        int busy_cnt;
        wait_idle8();
        start8 = 1'b1; a8 = a; b8 = b;
        q8.push_back({eo, SAT ? ed_sat : ed_wrap});
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        cycles = 1; busy_cnt = int'(busy8);
        while (!done8 && cycles < 40) begin
            @(negedge clk); cycles++; busy_cnt += int'(busy8);
        end
        check("latency8", 64'(cycles), 64'd9);
        check("busy8_cycles", 64'(busy_cnt), 64'd9);
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed_wrap, input logic [31:0] ed_sat, input logic eo);
        int cycles;
        int g = 0;
        @(negedge clk);
        while (busy32 && g < 100) begin @(negedge clk); g++; end
        start32 = 1'b1; a32 = a; b32 = b;
        q32.push_back({eo, SAT ? ed_sat : ed_wrap});
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        cycles = 1;
        while (!done32 && cycles < 80) begin @(negedge clk); cycles++; end
        check("latency32", 64'(cycles), 64'd33);
    endtask

    initial begin
        logic [7:0] va[3], vb[3], vw[3], vs[3];
        logic       vo[3];
        int k, g;

        // Reset state
        #1;
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_diff8", 64'(diff8), 64'd0);
        check("rst_ovf8", 64'(ovf8), 64'd0);
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_diff32", 64'(diff32), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed single ops: a, b, wrapped diff, saturated diff, ovf
        run8(8'h05, 8'h03, 8'h02, 8'h02, 1'b0);
        run8(8'h80, 8'h01, 8'h7F, 8'h80, 1'b1);
        run8(8'h7F, 8'hFF, 8'h80, 8'h7F, 1'b1);
        run8(8'hFF, 8'h7F, 8'h80, 8'h80, 1'b0);
        run8(8'h00, 8'h80, 8'h80, 8'h7F, 1'b1);
        run8(8'h03, 8'h05, 8'hFE, 8'hFE, 1'b0);

        // start held high, operands disturbed while running
        va = '{8'h0A, 8'h28, 8'h40};
        vb = '{8'h14, 8'hD8, 8'hC0};
        vw = '{8'hF6, 8'h50, 8'h80};
        vs = '{8'hF6, 8'h50, 8'h7F};
        vo = '{1'b0, 1'b0, 1'b1};
        wait_idle8();
        done_cyc.delete();
        start8 = 1'b1;
        k = 0; g = 0;
        while (k < 3 && g < 100) begin
            if (!busy8) begin
                a8 = va[k]; b8 = vb[k];
                q8.push_back({vo[k], SAT ? vs[k] : vw[k]});
                k++;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            @(negedge clk); g++;
        end
        start8 = 1'b0;
        g = 0;
        while (done_cyc.size() < 3 && g < 60) begin @(negedge clk); g++; end
        check("b2b_done_count", 64'(done_cyc.size()), 64'd3);
        if (done_cyc.size() == 3) begin
            check("b2b_spacing0", 64'(done_cyc[1] - done_cyc[0]), 64'd10);
            check("b2b_spacing1", 64'(done_cyc[2] - done_cyc[1]), 64'd10);
        end

        // Reset mid-RUN at cnt=4: no done, outputs cleared asynchronously
        wait_idle8();
        start8 = 1'b1; a8 = 8'h40; b8 = 8'h01;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy8", 64'(busy8), 64'd0);
        check("abort_done8", 64'(done8), 64'd0);
        check("abort_diff8", 64'(diff8), 64'd0);
        check("abort_ovf8", 64'(ovf8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        run8(8'h33, 8'h11, 8'h22, 8'h22, 1'b0);

        // Width=32
        run32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        run32(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);

        repeat (5) @(negedge clk);
        check("pending8", 64'(q8.size()), 64'd0);
        check("pending32", 64'(q32.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
